// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO burst reader
package fifo_rd_pkg;
    localparam int WIDTH      = 8;
    localparam int LEN_BITS   = 8;
    localparam int SKID_DEPTH = 2;

    typedef logic [WIDTH-1:0] fifo_unit;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        FLUSH,
        DONE
    } rd_state_e;
endpackage

// File: rtl/fifo_skid2.sv
// rtl/fifo_skid2.sv - two-entry registered skid buffer between FIFO read data and the output stream
module fifo_skid2
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);
    logic [WIDTH-1:0] ent0_q, ent0_d;
    logic [WIDTH-1:0] ent1_q, ent1_d;
    logic [1:0]       occ_q, occ_d;
    logic             deq;
    logic             enq;

    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        deq    = (occ_q != 2'd0) && out_ready;
        // A write into a full buffer is only taken when the head leaves in the same cycle.
        enq    = in_valid && ((occ_q != 2'(SKID_DEPTH)) || deq);
        case ({enq, deq})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    ent0_d = in_data;
                end else begin
                    ent1_d = in_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    ent0_d = in_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = in_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q <= '0;
            ent1_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            occ_q  <= occ_d;
        end
    end

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = ent0_q;
    assign occupancy = occ_q;
endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - drains a fixed-length burst from the FIFO read port onto a ready/valid stream
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int LEN_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_BITS-1:0] len,
    output logic                busy,
    output logic                done,
    output logic [LEN_BITS-1:0] rd_count,
    output logic                pop,
    input  logic                ept,
    input  logic                valid,
    input  logic [WIDTH-1:0]    r_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [WIDTH-1:0]    m_data
);
    localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);

    rd_state_e           state_q, state_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] issued_q, issued_d;
    logic [LEN_BITS-1:0] rd_count_q, rd_count_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [1:0]          occ;
    logic                rd_accept;
    logic                hs;

    assign pop       = (state_q == READ) && !ept && (issued_q < len_q) && (occ < 2'(SKID_DEPTH));
    assign rd_accept = pop && valid;
    assign hs        = m_valid && m_ready;

    fifo_skid2 #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (rd_accept),
        .in_data   (r_data),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (m_data),
        .occupancy (occ)
    );

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        issued_d   = issued_q;
        rd_count_d = hs ? (rd_count_q + ONE) : rd_count_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rd_count_d = '0;
                    if (len != '0) begin
                        state_d  = READ;
                        len_d    = len;
                        issued_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            READ: begin
                if (rd_accept) begin
                    issued_d = issued_q + ONE;
                    if ((issued_q + ONE) == len_q) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // Leave as the buffer drains so done lands right after the final handshake.
                if ((occ == 2'd0) || ((occ == 2'd1) && hs)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            issued_q   <= '0;
            rd_count_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            rd_count_q <= rd_count_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign rd_count = rd_count_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader against a FIFO and stream model
module tb_fifo_burst_reader;
    import fifo_rd_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       busy, done, pop, valid, ept, m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] rd_count, r_data, m_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    fifo_unit mem [256];
    int       wr_ptr = 0;
    int       rd_ptr = 0;
    bit       gap = 1'b0;
    bit       drop = 1'b0;

    int         pop_log[$];
    int         hs_log[$];
    int         done_log[$];
    fifo_unit   out_q[$];
    logic [7:0] done_rd_log[$];
    int         buf_n = 0;
    int         viol_pop = 0;
    int         viol_stable = 0;
    int         gap_pops = 0;
    bit         prev_stall = 1'b0;
    fifo_unit   prev_data = 8'd0;

    fifo_burst_reader #(.WIDTH(8), .LEN_BITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .rd_count (rd_count),
        .pop      (pop),
        .ept      (ept),
        .valid    (valid),
        .r_data   (r_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
    );

    always #5 clk = ~clk;

    assign ept    = (wr_ptr == rd_ptr) || gap;
    assign valid  = pop && !ept && !drop;
    assign r_data = mem[rd_ptr & 255];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop && valid) rd_ptr <= rd_ptr + 1;
    end

    // Observation log: events seen at negedge take effect at the following rising edge.
    always @(negedge clk) begin
        if (reset) begin
            buf_n = 0;
            prev_stall = 1'b0;
        end else begin
            if (pop) pop_log.push_back(cyc);
            if (pop && buf_n >= 2) viol_pop++;
            if (pop && gap) gap_pops++;
            if (prev_stall && (!m_valid || m_data !== prev_data)) viol_stable++;
            if (m_valid && m_ready) begin
                hs_log.push_back(cyc);
                out_q.push_back(m_data);
            end
            if (done) begin
                done_log.push_back(cyc);
                done_rd_log.push_back(rd_count);
            end
            buf_n = buf_n + ((pop && valid) ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            prev_stall = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    task automatic load(input fifo_unit w);
        mem[wr_ptr & 255] = w;
        wr_ptr++;
    endtask

    task automatic run_burst(input int l, input int rmode, input int g_lo, input int g_hi,
                             input bit rnd_drop, output int t0, output bit ok);
        int d0;
        @(posedge clk); #1;
        start = 1'b1;
        len = 8'(l);
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        d0 = done_log.size();
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            case (rmode)
                0: m_ready = 1'b1;
                1: m_ready = ((k % 4) == 0) || ((k % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            gap = (k >= g_lo) && (k < g_hi);
            drop = rnd_drop ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(posedge clk); #1;
            if (done_log.size() > d0) begin
                ok = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        gap = 1'b0;
        drop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        len = 8'd5;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, pop, m_valid} !== 4'b0 || rd_count !== 8'd0 || m_data !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: busy=%b done=%b pop=%b m_valid=%b rd_count=%0d m_data=%h, required all zero",
                         i, busy, done, pop, m_valid, rd_count, m_data);
            end
        end
        m_ready = 1'b1;
    endtask

    task automatic test_basic();
        int t0, p0, h0, d0;
        bit ok;
        p0 = pop_log.size(); h0 = hs_log.size(); d0 = done_log.size();
        for (int i = 0; i < 4; i++) load(8'h11 + 8'(i));
        run_burst(4, 0, 0, 0, 1'b0, t0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: done not seen, required within 400 cycles"); end
        checks++;
        if (pop_log.size() - p0 != 4 || pop_log[p0] != t0 || pop_log[p0+3] != t0 + 3) begin
            errors++;
            $display("FAIL basic_pop: %0d pops first=%0d, required 4 pops from cycle %0d", pop_log.size() - p0,
                     (pop_log.size() > p0) ? pop_log[p0] - t0 : -1, 0);
        end
        checks++;
        if (hs_log.size() - h0 != 4 || hs_log[h0] != t0 + 1 || hs_log[h0+3] != t0 + 4) begin
            errors++;
            $display("FAIL basic_hs_timing: %0d handshakes, required 4 on cycles +1..+4", hs_log.size() - h0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_q.size() <= h0 + i || out_q[h0+i] !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL basic_data[%0d]: got %h, required %h", i,
                         (out_q.size() > h0 + i) ? out_q[h0+i] : 8'hxx, 8'h11 + 8'(i));
            end
        end
        checks++;
        if (done_log.size() - d0 != 1 || done_log[d0] != t0 + 5 || done_rd_log[d0] !== 8'd4) begin
            errors++;
            $display("FAIL basic_done: count=%0d cycle=+%0d rd_count=%0d, required 1 at +5 with 4",
                     done_log.size() - d0, (done_log.size() > d0) ? done_log[d0] - t0 : -1,
                     (done_log.size() > d0) ? done_rd_log[d0] : 8'hxx);
        end
    endtask

    task automatic test_backpressure();
        int t0, p0, h0, d0, vp0, vs0;
        bit ok;
        p0 = pop_log.size(); h0 = hs_log.size(); d0 = done_log.size();
        vp0 = viol_pop; vs0 = viol_stable;
        for (int i = 0; i < 4; i++) load(8'h11 + 8'(i));
        run_burst(4, 1, 0, 0, 1'b0, t0, ok);
        checks++;
        if (!ok || done_log.size() - d0 != 1 || done_rd_log[d0] !== 8'd4) begin
            errors++;
            $display("FAIL bp_done: ok=%b count=%0d, required one done with rd_count 4", ok, done_log.size() - d0);
        end
        checks++;
        if (viol_stable != vs0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable stalled cycles, required 0", viol_stable - vs0);
        end
        checks++;
        if (viol_pop != vp0 || pop_log.size() - p0 != 4) begin
            errors++;
            $display("FAIL bp_pop: %0d pops while 2 buffered, %0d pops total, required 0 and 4",
                     viol_pop - vp0, pop_log.size() - p0);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_q.size() <= h0 + i || out_q[h0+i] !== 8'h11 + 8'(i)) begin
                errors++;
                $display("FAIL bp_data[%0d]: got %h, required %h", i,
                         (out_q.size() > h0 + i) ? out_q[h0+i] : 8'hxx, 8'h11 + 8'(i));
            end
        end
    endtask

    task automatic test_empty_gap();
        int t0, p0, h0, d0, g0, e0;
        bit ok;
        p0 = pop_log.size(); h0 = hs_log.size(); d0 = done_log.size(); g0 = gap_pops; e0 = rd_ptr;
        for (int i = 0; i < 3; i++) load(fifo_unit'($urandom));
        run_burst(3, 0, 2, 5, 1'b0, t0, ok);
        checks++;
        if (gap_pops != g0 || pop_log.size() - p0 != 3 || pop_log[p0+2] != t0 + 5) begin
            errors++;
            $display("FAIL gap_pop: %0d pops in gap, %0d pops, required 0 in gap, 3 total, last at +5",
                     gap_pops - g0, pop_log.size() - p0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_q.size() <= h0 + i || out_q[h0+i] !== mem[(e0 + i) & 255]) begin
                errors++;
                $display("FAIL gap_data[%0d]: got %h, required %h", i,
                         (out_q.size() > h0 + i) ? out_q[h0+i] : 8'hxx, mem[(e0 + i) & 255]);
            end
        end
        checks++;
        if (!ok || done_log.size() - d0 != 1 || hs_log.size() - h0 != 3 ||
            done_log[d0] != hs_log[h0+2] + 1 || done_rd_log[d0] !== 8'd3) begin
            errors++;
            $display("FAIL gap_done: ok=%b count=%0d hs=%0d, required one done right after 3rd handshake, rd_count 3",
                     ok, done_log.size() - d0, hs_log.size() - h0);
        end
    endtask

    task automatic test_len_zero();
        int t0, p0, d0;
        bit ok;
        p0 = pop_log.size(); d0 = done_log.size();
        run_burst(0, 0, 0, 0, 1'b0, t0, ok);
        checks++;
        if (!ok || done_log.size() - d0 != 1 || done_log[d0] != t0) begin
            errors++;
            $display("FAIL len0_done: ok=%b count=%0d, required one done at T+1", ok, done_log.size() - d0);
        end
        checks++;
        if (pop_log.size() != p0 || done_rd_log[d0] !== 8'd0) begin
            errors++;
            $display("FAIL len0_pop: pops=%0d rd_count=%0d, required 0 and 0", pop_log.size() - p0, done_rd_log[d0]);
        end
    endtask

    task automatic test_reset_mid();
        int t0, p0, h0, d0, e0;
        bit ok;
        p0 = pop_log.size();
        for (int i = 0; i < 8; i++) load(fifo_unit'($urandom));
        @(posedge clk); #1;
        m_ready = 1'b0;
        start = 1'b1;
        len = 8'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (pop_log.size() - p0 != 2 || m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_fill: pops=%0d m_valid=%b, required 2 and 1", pop_log.size() - p0, m_valid);
        end
        d0 = done_log.size();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: m_valid=%b busy=%b done=%b, required 0 0 0", m_valid, busy, done);
        end
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done_log.size() != d0) begin
            errors++;
            $display("FAIL rstmid_nodone: %0d done pulses, required 0", done_log.size() - d0);
        end
        h0 = hs_log.size(); d0 = done_log.size(); e0 = rd_ptr;
        run_burst(2, 0, 0, 0, 1'b0, t0, ok);
        checks++;
        if (!ok || done_log.size() - d0 != 1 || done_rd_log[d0] !== 8'd2 || hs_log.size() - h0 != 2 ||
            out_q[h0] !== mem[e0 & 255] || out_q[h0+1] !== mem[(e0 + 1) & 255]) begin
            errors++;
            $display("FAIL rstmid_after: ok=%b hs=%0d, required 2 words in order and done with rd_count 2",
                     ok, hs_log.size() - h0);
        end
    endtask

    task automatic test_random();
        int t0, h0, d0, e0, vp0, vs0, l, g_lo;
        bit ok;
        for (int b = 0; b < 6; b++) begin
            l = $urandom_range(1, 12);
            h0 = hs_log.size(); d0 = done_log.size(); e0 = rd_ptr;
            vp0 = viol_pop; vs0 = viol_stable;
            for (int i = 0; i < l; i++) load(fifo_unit'($urandom));
            g_lo = $urandom_range(0, 6);
            run_burst(l, 2, g_lo, g_lo + $urandom_range(0, 4), 1'b1, t0, ok);
            checks++;
            if (!ok || done_log.size() - d0 != 1 || done_rd_log[d0] !== 8'(l) || hs_log.size() - h0 != l) begin
                errors++;
                $display("FAIL rand%0d_done: ok=%b dones=%0d hs=%0d, required one done, %0d words", b, ok,
                         done_log.size() - d0, hs_log.size() - h0, l);
            end
            checks++;
            if (viol_pop != vp0 || viol_stable != vs0) begin
                errors++;
                $display("FAIL rand%0d_flow: pop_at_full=%0d unstable=%0d, required 0 0", b,
                         viol_pop - vp0, viol_stable - vs0);
            end
            for (int i = 0; i < l; i++) begin
                checks++;
                if (out_q.size() <= h0 + i || out_q[h0+i] !== mem[(e0 + i) & 255]) begin
                    errors++;
                    $display("FAIL rand%0d_data[%0d]: got %h, required %h", b, i,
                             (out_q.size() > h0 + i) ? out_q[h0+i] : 8'hxx, mem[(e0 + i) & 255]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty_gap();
        test_len_zero();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
